// File: rtl/assoc_pkg.sv
// Shared definitions for the sequential associative-memory controller path.
// Sizes here are the defaults that the controller and the argmax scanner take as parameters.
package assoc_pkg;

    localparam int NUM_CLASSES = 26;
    localparam int NUM_CHUNKS  = 16;
    localparam int SCORE_W     = 7;
    localparam int CLASS_W     = 5;
    localparam int CHUNK_W     = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_SCAN,
        S_DONE
    } assoc_ctrl_state_t;

endpackage

// File: rtl/assoc_argmax_seq.sv
// Sequential argmax over the accumulator bank: one class per enabled cycle.
// Ties keep the earlier index because a candidate replaces the best only when it is strictly greater.
module assoc_argmax_seq #(
    parameter int NUM_CLASSES = assoc_pkg::NUM_CLASSES,
    parameter int SCORE_W     = assoc_pkg::SCORE_W,
    parameter int CLASS_W     = assoc_pkg::CLASS_W
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           scan_en,
    input  logic                           scan_first,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores_flat,
    output logic [CLASS_W-1:0]             best_idx,
    output logic [SCORE_W-1:0]             best_score,
    output logic                           scan_last
);

    logic [CLASS_W-1:0] scan_idx_q, scan_idx_d;
    logic [CLASS_W-1:0] best_idx_q, best_idx_d;
    logic [SCORE_W-1:0] best_score_q, best_score_d;
    logic [SCORE_W-1:0] cand;

    always_comb begin
        cand = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (scan_idx_q == CLASS_W'(k)) begin
                cand = scores_flat[k*SCORE_W +: SCORE_W];
            end
        end
    end

    assign scan_last = scan_en && (scan_idx_q == CLASS_W'(NUM_CLASSES - 1));

    // The index wraps to zero after the last class so the next query starts at class 0.
    always_comb begin
        scan_idx_d   = scan_idx_q;
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        if (scan_en) begin
            scan_idx_d = scan_last ? '0 : scan_idx_q + CLASS_W'(1);
            if (scan_first || (cand > best_score_q)) begin
                best_idx_d   = scan_idx_q;
                best_score_d = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            scan_idx_q   <= '0;
            best_idx_q   <= '0;
            best_score_q <= '0;
        end else begin
            scan_idx_q   <= scan_idx_d;
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
        end
    end

    assign best_idx   = best_idx_q;
    assign best_score = best_score_q;

endmodule

// File: rtl/assoc_seq_ctrl.sv
// Paces chunk scores into the 26-class accumulator bank, then scans the bank for the winning
// class and offers it on a valid/ready result port.
module assoc_seq_ctrl #(
    parameter int NUM_CLASSES = assoc_pkg::NUM_CLASSES,
    parameter int NUM_CHUNKS  = assoc_pkg::NUM_CHUNKS,
    parameter int SCORE_W     = assoc_pkg::SCORE_W,
    parameter int CLASS_W     = assoc_pkg::CLASS_W
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           start,
    output logic                           busy,
    input  logic                           chunk_valid,
    output logic                           chunk_ready,
    output logic                           acc_en,
    output logic [assoc_pkg::CHUNK_W-1:0]  state,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores_flat,
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic [CLASS_W-1:0]             class_out,
    output logic [SCORE_W-1:0]             max_score
);

    import assoc_pkg::*;

    assoc_ctrl_state_t  fsm_q;
    logic [CHUNK_W-1:0] chunk_cnt_q;
    logic               busy_q;
    logic               chunk_ready_q;
    logic               result_valid_q;
    logic               scan_first_q;
    logic               scan_en;
    logic               scan_last;

    assign acc_en  = chunk_valid & chunk_ready_q;
    assign scan_en = (fsm_q == S_SCAN);

    // The chunk counter stops on the final chunk rather than wrapping, so it doubles as the
    // bank's chunk index and naturally holds its last value outside ACCUM.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fsm_q          <= S_IDLE;
            chunk_cnt_q    <= '0;
            busy_q         <= 1'b0;
            chunk_ready_q  <= 1'b0;
            result_valid_q <= 1'b0;
            scan_first_q   <= 1'b0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (start) begin
                        fsm_q         <= S_ACCUM;
                        chunk_cnt_q   <= '0;
                        busy_q        <= 1'b1;
                        chunk_ready_q <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (acc_en) begin
                        if (chunk_cnt_q == CHUNK_W'(NUM_CHUNKS - 1)) begin
                            fsm_q         <= S_SCAN;
                            chunk_ready_q <= 1'b0;
                            scan_first_q  <= 1'b1;
                        end else begin
                            chunk_cnt_q <= chunk_cnt_q + CHUNK_W'(1);
                        end
                    end
                end
                S_SCAN: begin
                    scan_first_q <= 1'b0;
                    if (scan_last) begin
                        fsm_q          <= S_DONE;
                        result_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        fsm_q          <= S_IDLE;
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                    end
                end
                default: begin
                    fsm_q <= S_IDLE;
                end
            endcase
        end
    end

    assoc_argmax_seq #(
        .NUM_CLASSES (NUM_CLASSES),
        .SCORE_W     (SCORE_W),
        .CLASS_W     (CLASS_W)
    ) u_argmax (
        .clk         (clk),
        .nrst        (nrst),
        .scan_en     (scan_en),
        .scan_first  (scan_first_q),
        .scores_flat (scores_flat),
        .best_idx    (class_out),
        .best_score  (max_score),
        .scan_last   (scan_last)
    );

    assign busy         = busy_q;
    assign chunk_ready  = chunk_ready_q;
    assign state        = chunk_cnt_q;
    assign result_valid = result_valid_q;

endmodule
